// File: rtl/aes_mode_engine.sv
// AES-128 block-mode engine. It runs ECB, CBC or CTR around one iterative
// aes_encrypt core and buffers the results in a small output FIFO.
// This file also holds aes_encrypt, the iterative AES-128 core the engine uses.

// Iterative AES-128 encryptor: one round per clock, done pulses with the result.
module aes_encrypt (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic [127:0] ciphertext,
   output logic         done
);

   logic [127:0] st_q;
   logic [127:0] rk_q;
   logic [127:0] rk_nxt;
   logic [7:0]   rc_q;
   logic [3:0]   rnd_q;
   logic         run_q;
   logic         done_q;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   // S-box from its definition: GF(2^8) inverse (b^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] r;
      p = b;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
             {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t;
      logic [31:0] n0;
      logic [31:0] n1;
      logic [31:0] n2;
      logic [31:0] n3;
      t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
      n0 = k[127:96] ^ t;
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // SubBytes, ShiftRows and (except in the final round) MixColumns
   function automatic logic [127:0] enc_round(input logic [127:0] s, input logic last_rnd);
      logic [7:0]   sb [16];
      logic [7:0]   sr [16];
      logic [7:0]   a0;
      logic [7:0]   a1;
      logic [7:0]   a2;
      logic [7:0]   a3;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++) sr[w+4*c] = sb[w+4*((c+w)%4)];
      r = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = sr[4*c];
         a1 = sr[4*c+1];
         a2 = sr[4*c+2];
         a3 = sr[4*c+3];
         if (last_rnd) r[127-32*c -: 32] = {a0, a1, a2, a3};
         else r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                   xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
      return r;
   endfunction

   // Round key for the round being computed this cycle
   always_comb begin
      rk_nxt = next_key(rk_q, rc_q);
   end

   // Round iteration: start loads the whitened block, ten rounds follow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q   <= '0;
         rk_q   <= '0;
         rc_q   <= 8'h00;
         rnd_q  <= 4'd0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            st_q  <= plaintext ^ key;
            rk_q  <= key;
            rc_q  <= 8'h01;
            rnd_q <= 4'd1;
            run_q <= 1'b1;
         end else if (run_q) begin
            st_q  <= enc_round(st_q, rnd_q == 4'd10) ^ rk_nxt;
            rk_q  <= rk_nxt;
            rc_q  <= xt(rc_q);
            rnd_q <= rnd_q + 4'd1;
            if (rnd_q == 4'd10) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign ciphertext = st_q;
   assign done       = done_q;

endmodule

module aes_mode_engine #(
   parameter int unsigned CTR_WIDTH = 32,
   parameter int unsigned OUT_DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         cfg_load_i,
   input  logic [1:0]   cfg_mode_i,
   input  logic [127:0] cfg_key_i,
   input  logic [127:0] cfg_iv_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [127:0] in_data_i,
   input  logic         in_last_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [127:0] out_data_o,
   output logic         out_last_o,
   output logic         busy_o,
   output logic         err_o
);

   localparam int unsigned BW = 128;
   localparam int unsigned AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [BW-1:0] CTR_MASK = {BW{1'b1}} >> (BW - CTR_WIDTH);

   localparam logic [1:0] MODE_ECB = 2'b00;
   localparam logic [1:0] MODE_CBC = 2'b01;
   localparam logic [1:0] MODE_CTR = 2'b10;
   localparam logic [1:0] MODE_ILL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READY,
      ST_START,
      ST_WAIT,
      ST_PUSH
   } state_e;

   state_e        state_q;
   logic [1:0]    mode_q;
   logic [BW-1:0] key_q;
   logic [BW-1:0] iv_q;
   logic [BW-1:0] chain_q;
   logic [BW-1:0] ctr_q;
   logic [BW-1:0] data_q;
   logic [BW-1:0] core_in_q;
   logic [BW-1:0] res_q;
   logic          last_q;
   logic          start_q;
   logic          in_ready_q;
   logic          busy_q;
   logic          err_q;

   logic [BW:0]   mem_q [OUT_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          out_valid_q;

   logic          cfg_idle_c;
   logic          cfg_ok_c;
   logic          cfg_bad_c;
   logic          accept_c;
   logic          full_c;
   logic          pop_c;
   logic          push_c;
   logic [1:0]    eff_mode_c;
   logic [BW-1:0] eff_chain_c;
   logic [BW-1:0] eff_ctr_c;
   logic [BW-1:0] core_in_c;
   logic [BW-1:0] ctr_inc_c;
   logic [BW-1:0] core_ct;
   logic          core_done;

   aes_encrypt u_core (
      .clk        (clk_i),
      .rst        (~rst_ni),
      .start      (start_q),
      .plaintext  (core_in_q),
      .key        (key_q),
      .ciphertext (core_ct),
      .done       (core_done)
   );

   assign cfg_idle_c = (state_q == ST_IDLE) || (state_q == ST_READY);
   assign cfg_ok_c   = cfg_load_i && cfg_idle_c && (cfg_mode_i != MODE_ILL);
   assign cfg_bad_c  = cfg_load_i && !cfg_ok_c;
   assign accept_c   = in_valid_i && in_ready_q;
   assign full_c     = (cnt_q == CW'(OUT_DEPTH));
   assign pop_c      = out_valid_q && out_ready_i;
   assign push_c     = (state_q == ST_PUSH) && (!full_c || pop_c);

   // Core input for an accepted block; a load in the same cycle applies to that block
   always_comb begin
      eff_mode_c  = mode_q;
      eff_chain_c = chain_q;
      eff_ctr_c   = ctr_q;
      core_in_c   = in_data_i;
      if (cfg_ok_c) begin
         eff_mode_c  = cfg_mode_i;
         eff_chain_c = cfg_iv_i;
         eff_ctr_c   = cfg_iv_i;
      end
      case (eff_mode_c)
         MODE_CBC: core_in_c = in_data_i ^ eff_chain_c;
         MODE_CTR: core_in_c = eff_ctr_c;
         default:  core_in_c = in_data_i;
      endcase
      // Only the low CTR_WIDTH bits count; the carry out of them is dropped
      ctr_inc_c = (eff_ctr_c & ~CTR_MASK) | ((eff_ctr_c + BW'(1)) & CTR_MASK);
   end

   // Control FSM with its registered handshake and status outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_ECB;
         key_q      <= '0;
         iv_q       <= '0;
         chain_q    <= '0;
         ctr_q      <= '0;
         data_q     <= '0;
         core_in_q  <= '0;
         res_q      <= '0;
         last_q     <= 1'b0;
         start_q    <= 1'b0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         start_q <= 1'b0;
         if (cfg_bad_c) err_q <= 1'b1;
         unique case (state_q)
            ST_IDLE, ST_READY: begin
               if (cfg_bad_c) begin
                  // Illegal mode: back to unconfigured; a block offered now is dropped
                  state_q    <= ST_IDLE;
                  in_ready_q <= 1'b0;
               end else begin
                  if (cfg_ok_c) begin
                     key_q      <= cfg_key_i;
                     mode_q     <= cfg_mode_i;
                     iv_q       <= cfg_iv_i;
                     chain_q    <= cfg_iv_i;
                     ctr_q      <= cfg_iv_i;
                     err_q      <= 1'b0;
                     state_q    <= ST_READY;
                     in_ready_q <= 1'b1;
                  end
                  if (accept_c) begin
                     data_q     <= in_data_i;
                     last_q     <= in_last_i;
                     core_in_q  <= core_in_c;
                     if (eff_mode_c == MODE_CTR) ctr_q <= ctr_inc_c;
                     start_q    <= 1'b1;
                     state_q    <= ST_START;
                     in_ready_q <= 1'b0;
                     busy_q     <= 1'b1;
                  end
               end
            end
            ST_START: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (core_done) begin
                  res_q   <= (mode_q == MODE_CTR) ? (data_q ^ core_ct) : core_ct;
                  if (mode_q == MODE_CBC) chain_q <= core_ct;
                  state_q <= ST_PUSH;
               end
            end
            ST_PUSH: begin
               if (push_c) begin
                  state_q    <= ST_READY;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
                  if (last_q) begin
                     chain_q <= iv_q;
                     ctr_q   <= iv_q;
                  end
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   // Next occupancy of the output buffer
   always_comb begin
      cnt_d = cnt_q;
      if (push_c && !pop_c) cnt_d = cnt_q + CW'(1);
      else if (pop_c && !push_c) cnt_d = cnt_q - CW'(1);
   end

   // Output buffer pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q       <= cnt_d;
         out_valid_q <= (cnt_d != '0);
      end
   end

   // Output buffer storage
   always_ff @(posedge clk_i) begin
      if (push_c) mem_q[wr_ptr_q] <= {last_q, res_q};
   end

   assign in_ready_o  = in_ready_q;
   assign busy_o      = busy_q;
   assign err_o       = err_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_valid_q ? mem_q[rd_ptr_q][BW-1:0] : '0;
   assign out_last_o  = out_valid_q ? mem_q[rd_ptr_q][BW] : 1'b0;

endmodule

// File: tb/tb_aes_mode_engine.sv
// Scoreboard bench for aes_mode_engine against a byte-level AES reference model.
module tb_aes_mode_engine;

   localparam int unsigned CTR_W = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cfg_load;
   logic [1:0]   cfg_mode;
   logic [127:0] cfg_key;
   logic [127:0] cfg_iv;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         out_last;
   logic         busy;
   logic         err;

   typedef struct packed {
      logic [127:0] d;
      logic         l;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         mon_e;
   int           n_cmp = 0;
   int           n_bad = 0;
   int           n_acc = 0;
   int           n_out = 0;
   bit           rand_rdy = 1'b0;
   bit           bp_done;

   logic [7:0]   sbox_t [256];
   logic [1:0]   m_mode;
   logic [127:0] m_key;
   logic [127:0] m_iv;
   logic [127:0] m_chain;
   logic [127:0] m_ctr;

   aes_mode_engine #(.CTR_WIDTH(CTR_W), .OUT_DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cfg_load_i  (cfg_load),
      .cfg_mode_i  (cfg_mode),
      .cfg_key_i   (cfg_key),
      .cfg_iv_i    (cfg_iv),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .in_last_i   (in_last),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_last_o  (out_last),
      .busy_o      (busy),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
      return (x << s) | (x >> (8 - s));
   endfunction

   // Build the S-box by walking the multiplicative group with generator 3
   function automatic void build_sbox();
      logic [7:0] p;
      logic [7:0] q;
      logic [7:0] x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endfunction

   // Textbook AES-128 on a byte array with a full expanded key schedule
   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
      logic [7:0]   w [176];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   t0;
      logic [7:0]   t1;
      logic [7:0]   t2;
      logic [7:0]   t3;
      logic [7:0]   tmp;
      logic [7:0]   rc;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
      rc = 8'h01;
      for (int i = 16; i < 176; i += 4) begin
         t0 = w[i-4]; t1 = w[i-3]; t2 = w[i-2]; t3 = w[i-1];
         if (i % 16 == 0) begin
            tmp = t0;
            t0  = sbox_t[t1] ^ rc;
            t1  = sbox_t[t2];
            t2  = sbox_t[t3];
            t3  = sbox_t[tmp];
            rc  = gm(rc, 8'h02);
         end
         w[i] = w[i-16] ^ t0; w[i+1] = w[i-15] ^ t1;
         w[i+2] = w[i-14] ^ t2; w[i+3] = w[i-13] ^ t3;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w_ = 0; w_ < 4; w_++) t[w_+4*c] = s[w_+4*((c+w_)%4)];
         for (int c = 0; c < 4; c++)
            for (int w_ = 0; w_ < 4; w_++)
               if (rnd < 10)
                  s[w_+4*c] = gm(8'h02, t[w_+4*c]) ^ gm(8'h03, t[(w_+1)%4+4*c]) ^
                              t[(w_+2)%4+4*c] ^ t[(w_+3)%4+4*c];
               else
                  s[w_+4*c] = t[w_+4*c];
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
      return r;
   endfunction

   // Mode behaviour: the expected output for the next block of the message
   function automatic logic [127:0] model_step(input logic [127:0] d, input logic l);
      logic [127:0] r;
      case (m_mode)
         2'b00: r = aes_ref(d, m_key);
         2'b01: begin
            r = aes_ref(d ^ m_chain, m_key);
            m_chain = r;
         end
         2'b10: begin
            r = d ^ aes_ref(m_ctr, m_key);
            m_ctr = {m_ctr[127:CTR_W], m_ctr[CTR_W-1:0] + CTR_W'(1)};
         end
         default: r = '0;
      endcase
      if (l) begin
         m_chain = m_iv;
         m_ctr   = m_iv;
      end
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic wait_not_busy();
      int t;
      t = 0;
      while (busy && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (busy) timeout("wait_not_busy");
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0 || busy) timeout("wait_drain");
   endtask

   task automatic do_cfg(input logic [1:0] md, input logic [127:0] k, input logic [127:0] iv,
                         input bit upd);
      wait_not_busy();
      @(negedge clk);
      cfg_load = 1'b1;
      cfg_mode = md;
      cfg_key  = k;
      cfg_iv   = iv;
      @(negedge clk);
      cfg_load = 1'b0;
      if (upd) begin
         m_mode  = md;
         m_key   = k;
         m_iv    = iv;
         m_chain = iv;
         m_ctr   = iv;
      end
   endtask

   task automatic send(input logic [127:0] d, input logic l, input bit use_ov,
                       input logic [127:0] ov);
      logic [127:0] e;
      exp_t         x;
      int           t;
      e = model_step(d, l);
      if (use_ov) e = ov;
      x.d = e;
      x.l = l;
      exp_q.push_back(x);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      t = 0;
      while (!in_ready && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         timeout("send_accept");
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      n_acc++;
      #1 in_valid = 1'b0;
   endtask

   task automatic rand_msgs(input logic [1:0] md, input int nmsg);
      int len;
      do_cfg(md, rand128(), rand128(), 1'b1);
      for (int m = 0; m < nmsg; m++) begin
         len = $urandom_range(1, 3);
         for (int b = 0; b < len; b++) send(rand128(), b == len - 1, 1'b0, '0);
      end
      wait_drain();
   endtask

   // Random output backpressure while enabled
   always @(posedge clk) begin
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: every output transfer is checked against the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            timeout("out_unexpected");
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_data", out_data, mon_e.d);
            chk("out_last", 128'(out_last), 128'(mon_e.l));
         end
         n_out++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] iv;
      build_sbox();
      rst_n     = 1'b0;
      cfg_load  = 1'b0;
      cfg_mode  = 2'b00;
      cfg_key   = '0;
      cfg_iv    = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      m_mode = 2'b00; m_key = '0; m_iv = '0; m_chain = '0; m_ctr = '0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      chk("rst_out_data", out_data, '0);
      chk("rst_out_last", 128'(out_last), 128'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_in_ready", 128'(in_ready), 128'(0));

      // ECB known answer
      do_cfg(2'b00, FIPS_KEY, '0, 1'b1);
      chk("cfg_in_ready", 128'(in_ready), 128'(1));
      send(FIPS_PT, 1'b1, 1'b1, FIPS_CT);
      wait_drain();

      // CBC known answer then a chained block
      do_cfg(2'b01, FIPS_KEY, '0, 1'b1);
      send(FIPS_PT, 1'b0, 1'b1, FIPS_CT);
      send(rand128(), 1'b1, 1'b0, '0);
      wait_drain();

      // CTR known answer
      do_cfg(2'b10, FIPS_KEY, FIPS_PT, 1'b1);
      send('0, 1'b0, 1'b1, FIPS_CT);
      send(rand128(), 1'b1, 1'b0, '0);
      wait_drain();

      // CTR counter wrap in the low bits, then a second message from the same IV
      iv = {rand128() >> 32, 32'hffffffff};
      do_cfg(2'b10, rand128(), iv, 1'b1);
      for (int b = 0; b < 3; b++) send(rand128(), b == 2, 1'b0, '0);
      for (int b = 0; b < 2; b++) send(rand128(), b == 1, 1'b0, '0);
      wait_drain();

      // Random messages under random backpressure
      rand_rdy = 1'b1;
      rand_msgs(2'b00, 3);
      rand_msgs(2'b01, 3);
      rand_msgs(2'b10, 3);
      rand_rdy = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b1;

      // Full output buffer stalls the engine
      do_cfg(2'b00, rand128(), '0, 1'b1);
      @(posedge clk);
      #1 out_ready = 1'b0;
      n_acc   = 0;
      bp_done = 1'b0;
      fork
         begin
            for (int b = 0; b < 6; b++) send(rand128(), b == 5, 1'b0, '0);
            bp_done = 1'b1;
         end
      join_none
      repeat (200) @(negedge clk);
      chk("bp_accepted", 128'(n_acc), 128'(DEPTH + 1));
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_busy", 128'(busy), 128'(1));
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      @(posedge clk);
      #1 out_ready = 1'b1;
      for (int t = 0; t < 3000 && !bp_done; t++) @(negedge clk);
      if (!bp_done) timeout("bp_release");
      wait_drain();
      chk("bp_total", 128'(n_acc), 128'(6));

      // Illegal mode
      do_cfg(2'b11, rand128(), rand128(), 1'b0);
      chk("ill_err", 128'(err), 128'(1));
      chk("ill_in_ready", 128'(in_ready), 128'(0));
      chk("ill_busy", 128'(busy), 128'(0));
      do_cfg(2'b00, rand128(), '0, 1'b1);
      chk("legal_clears_err", 128'(err), 128'(0));
      chk("legal_in_ready", 128'(in_ready), 128'(1));

      // Load attempt while the core is working is refused
      send(rand128(), 1'b1, 1'b0, '0);
      repeat (3) @(negedge clk);
      cfg_load = 1'b1;
      cfg_mode = 2'b01;
      cfg_key  = rand128();
      cfg_iv   = rand128();
      @(negedge clk);
      cfg_load = 1'b0;
      chk("busy_cfg_err", 128'(err), 128'(1));
      chk("busy_cfg_busy", 128'(busy), 128'(1));
      wait_drain();
      send(rand128(), 1'b1, 1'b0, '0);
      wait_drain();
      chk("err_sticky", 128'(err), 128'(1));

      // Reset in the middle of a block
      send(rand128(), 1'b0, 1'b0, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
      chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_busy", 128'(busy), 128'(0));
      chk("mid_rst_err", 128'(err), 128'(0));
      chk("mid_rst_out_data", out_data, '0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_in_ready", 128'(in_ready), 128'(0));
      chk("post_rst_out_valid", 128'(out_valid), 128'(0));
      chk("post_rst_busy", 128'(busy), 128'(0));
      do_cfg(2'b00, FIPS_KEY, '0, 1'b1);
      send(FIPS_PT, 1'b1, 1'b1, FIPS_CT);
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
